// File: rtl/pc_seq_pkg.sv
// Package for the segmented-carry PC sequencer.
// Holds the request mode encoding and the default carry-segment width.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    PC_INC1 = 2'b00,
    PC_INC2 = 2'b01,
    PC_LOAD = 2'b10,
    PC_HOLD = 2'b11
  } pc_mode_t;

  localparam int SEG_DEF = 4;

endpackage

// File: rtl/pc_seg_inc.sv
// One carry segment of the PC sequencer: increments a SEG-bit slice and
// flags when the slice is all ones (the slice would propagate a carry).
// Ports:
//   i_seg  in  SEG  segment value
//   o_inc  out SEG  segment value + 1 (wraps within the segment)
//   o_ones out 1    segment is all ones
module pc_seg_inc
  import pc_seq_pkg::*;
#(
  parameter int SEG = SEG_DEF
) (
  input  logic [SEG-1:0] i_seg,
  output logic [SEG-1:0] o_inc,
  output logic           o_ones
);

  assign o_inc  = i_seg + SEG'(1);
  assign o_ones = &i_seg;

endmodule

// File: rtl/pc_seq_pipe.sv
// Two-stage PC sequencer with segmented carry and valid/ready handshakes.
// S1 registers per-segment increments and all-ones flags; S2 resolves the
// carry chain across segments and selects INC1/INC2/LOAD/HOLD.
// Optional feature: define PC_SEQ_OVF_EN to add the out_ovf port, which
// flags an INC1/INC2 result that wrapped past all-ones.
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      request present
//   in_ready   out  1      request can be accepted this cycle
//   in_pc      in   WIDTH  current PC
//   in_mode    in   2      00 INC1, 01 INC2, 10 LOAD, 11 HOLD
//   in_target  in   WIDTH  branch target (LOAD only)
//   out_valid  out  1      result present
//   out_ready  in   1      downstream accepts result
//   out_pc     out  WIDTH  next PC
//   out_ovf    out  1      increment wrapped (PC_SEQ_OVF_EN only)
module pc_seq_pipe
  import pc_seq_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int SEG          = SEG_DEF,
  parameter bit STEP2_EN_DEF = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc
`ifdef PC_SEQ_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int NSEG = WIDTH / SEG;

  pc_mode_t         w_mode;
  logic [WIDTH-1:0] w_opnd;
  logic [WIDTH-1:0] w_inc;
  logic [NSEG-1:0]  w_ones;
  logic             w_adv2;
  logic             w_acc;

  logic             r_vld_p1;
  logic [WIDTH-1:0] r_inc_p1;
  logic [NSEG-1:0]  r_ones_p1;
  pc_mode_t         r_mode_p1;
  logic [WIDTH-1:0] r_tgt_p1;
  logic [WIDTH-1:0] r_pc_p1;

  logic [NSEG:0]    w_carry;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_res;

  logic             r_vld_p2;
  logic [WIDTH-1:0] r_pc_p2;

  // Handshake: a stage advances when the stage after it is empty or draining.
  assign w_adv2   = !r_vld_p2 || out_ready;
  assign in_ready = !r_vld_p1 || !r_vld_p2 || out_ready;
  assign w_acc    = in_valid && in_ready;

  // ---- S1 input side: mode resolution and per-segment increment ----
  always_comb begin
    w_mode = pc_mode_t'(in_mode);
    if (w_mode == PC_INC2 && !STEP2_EN_DEF) w_mode = PC_INC1;
  end

  // INC2 forces bit 0 high so a +1 on the operand carries into bit 1;
  // the original bit 0 is restored when the result is formed in S2.
  assign w_opnd = (w_mode == PC_INC2) ? (in_pc | WIDTH'(1)) : in_pc;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    pc_seg_inc #(.SEG(SEG)) u_seg (
      .i_seg  (w_opnd[k*SEG +: SEG]),
      .o_inc  (w_inc[k*SEG +: SEG]),
      .o_ones (w_ones[k])
    );
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_inc_p1  <= w_inc;
      r_ones_p1 <= w_ones;
      r_mode_p1 <= w_mode;
      r_tgt_p1  <= in_target;
      r_pc_p1   <= in_pc;
    end
  end

  // ---- S2: carry resolution across segments and result select ----
  // Segments above bit 0 of the operand equal the original PC, so the
  // pass-through value can come straight from r_pc_p1.
  assign w_carry[0] = 1'b1;
  for (genvar k = 0; k < NSEG; k++) begin : g_sel
    assign w_carry[k+1]         = w_carry[k] & r_ones_p1[k];
    assign w_sum[k*SEG +: SEG]  = w_carry[k] ? r_inc_p1[k*SEG +: SEG]
                                             : r_pc_p1[k*SEG +: SEG];
  end

  always_comb begin
    w_res = r_pc_p1;
    case (r_mode_p1)
      PC_INC1: w_res = w_sum;
      PC_INC2: w_res = {w_sum[WIDTH-1:1], r_pc_p1[0]};
      PC_LOAD: w_res = r_tgt_p1;
      default: w_res = r_pc_p1;
    endcase
  end

`ifdef PC_SEQ_OVF_EN
  logic w_ovf;
  logic r_ovf_p2;
  assign w_ovf   = w_carry[NSEG] &&
                   (r_mode_p1 == PC_INC1 || r_mode_p1 == PC_INC2);
  assign out_ovf = r_ovf_p2;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = w_carry[NSEG];
`endif

  // ---- S1/S2 control and output registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_pc_p2  <= '0;
`ifdef PC_SEQ_OVF_EN
      r_ovf_p2 <= 1'b0;
`endif
    end else begin
      if (in_ready) r_vld_p1 <= in_valid;
      if (w_adv2) begin
        r_vld_p2 <= r_vld_p1;
        if (r_vld_p1) begin
          r_pc_p2  <= w_res;
`ifdef PC_SEQ_OVF_EN
          r_ovf_p2 <= w_ovf;
`endif
        end
      end
    end
  end

  assign out_valid = r_vld_p2;
  assign out_pc    = r_pc_p2;

endmodule
